eject_arbiter: RTL and testbench

- Local-ejection arbiter for the 4-port mesh router.
- Compares each input port's 2-bit destination header against the router's own address and picks one matching port by round-robin.
- Holds that port as owner of the local eject sink for a full packet of PKT_FLITS flits, with a valid/ready handshake to the sink.
- Sits between the four input buffers and the local eject mux; drives the mux select and per-port dequeue acks.

---
 rtl/eject_arbiter_if.sv | 25 ++
 rtl/eject_arbiter.sv | 98 +++++++++
 tb/tb_eject_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/eject_arbiter_if.sv
// Input-buffer/eject-sink bundle for the local ejection arbiter.
// slave = arbiter side, master = the buffers and sink driving it.
interface eject_arbiter_if;
   logic [1:0] address;
   logic       valid1, valid2, valid3, valid4;
   logic [1:0] header1, header2, header3, header4;
   logic       ejectReady;
   logic [3:0] grant;
   logic [1:0] ejectSel;
   logic       ejectValid;
   logic       ack1, ack2, ack3, ack4;
   logic       busy;

   modport master (
      output address, valid1, valid2, valid3, valid4,
      output header1, header2, header3, header4, ejectReady,
      input  grant, ejectSel, ejectValid, ack1, ack2, ack3, ack4, busy
   );

   modport slave (
      input  address, valid1, valid2, valid3, valid4,
      input  header1, header2, header3, header4, ejectReady,
      output grant, ejectSel, ejectValid, ack1, ack2, ack3, ack4, busy
   );
endinterface

// File: rtl/eject_arbiter.sv
// Round-robin local-eject arbiter: 1-cycle match-to-grant, owner held for PKT_FLITS acks.
// Backpressure: ejectReady low or owner valid low stalls the packet; one idle cycle per release.
module eject_arbiter #(
   parameter int PKT_FLITS = 4,
   parameter int CNT_W     = 3
) (
   input logic          clk,
   input logic          rst,
   eject_arbiter_if.slave ej
);

   localparam logic [0:0]       IDLE = 1'b0;
   localparam logic [0:0]       BUSY = 1'b1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_FLITS - 1);

   logic [0:0]       state;
   logic [3:0]       grant_q;
   logic [1:0]       sel_q;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] cnt;

   logic [3:0] valid_v;
   logic [3:0] match_v;
   logic [3:0] ack_v;
   logic [1:0] win;
   logic [1:0] idx;
   logic       found;
   logic       fire;

   assign valid_v = {ej.valid4, ej.valid3, ej.valid2, ej.valid1};

   assign match_v[0] = ej.valid1 & ~|(ej.header1 ^ ej.address);
   assign match_v[1] = ej.valid2 & ~|(ej.header2 ^ ej.address);
   assign match_v[2] = ej.valid3 & ~|(ej.header3 ^ ej.address);
   assign match_v[3] = ej.valid4 & ~|(ej.header4 ^ ej.address);

   // Scan from ptr+3 down to ptr so the port nearest the pointer wins.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (match_v[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign ej.ejectValid = !rst && (state == BUSY) && valid_v[sel_q];
   assign fire          = ej.ejectValid & ej.ejectReady;
   assign ack_v         = fire ? grant_q : 4'b0000;

   assign ej.ack1     = ack_v[0];
   assign ej.ack2     = ack_v[1];
   assign ej.ack3     = ack_v[2];
   assign ej.ack4     = ack_v[3];
   assign ej.grant    = grant_q;
   assign ej.ejectSel = sel_q;
   assign ej.busy     = (state == BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= 4'b0000;
         sel_q   <= 2'd0;
         ptr     <= 2'd0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state   <= BUSY;
                  grant_q <= 4'b0001 << win;
                  sel_q   <= win;
                  cnt     <= '0;
               end
            end
            BUSY: begin
               if (fire) begin
                  if (cnt == LAST) begin
                     // ejectSel intentionally keeps the last owner across release.
                     state   <= IDLE;
                     grant_q <= 4'b0000;
                     cnt     <= '0;
                     ptr     <= sel_q + 2'd1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eject_arbiter.sv
// Directed bench for eject_arbiter with an ack scoreboard and per-cycle invariant monitor.
module tb_eject_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eject_arbiter_if ej ();

   eject_arbiter #(.PKT_FLITS(4), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .ej  (ej)
   );

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   logic [3:0] acks;
   assign acks = {ej.ack4, ej.ack3, ej.ack2, ej.ack1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int port, input int n);
      repeat (n) exp_q.push_back(port);
   endtask

   task automatic set_ports(input logic [3:0] v, input logic [7:0] hdr);
      ej.valid1  = v[0];
      ej.valid2  = v[1];
      ej.valid3  = v[2];
      ej.valid4  = v[3];
      ej.header1 = hdr[1:0];
      ej.header2 = hdr[3:2];
      ej.header3 = hdr[5:4];
      ej.header4 = hdr[7:6];
   endtask

   // Monitor: invariants every cycle, ack scoreboard whenever an ack is presented.
   always @(negedge clk) begin
      int e;
      logic [3:0] want;
      chk("inv_grant_onehot0", 32'($onehot0(ej.grant)), 32'd1);
      chk("inv_single_ack", 32'($onehot0(acks)), 32'd1);
      chk("inv_ack_has_grant", 32'(acks & ~ej.grant), 32'd0);
      if (ej.busy)
         chk("inv_sel_matches_grant", 32'(ej.grant), 32'(4'b0001 << ej.ejectSel));
      if (acks != 4'b0000) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_ack", 32'(acks), 32'd0);
         end else begin
            e    = exp_q.pop_front();
            want = 4'b0001 << (e - 1);
            chk("sb_ack_port", 32'(acks), 32'(want));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [7:0] HDR_MATCH = 8'b10101010;
   int vt[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
   int rt[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
   int order[5] = '{1, 2, 3, 4, 1};

   initial begin
      // Reset with every port matching
      rst           = 1'b1;
      ej.address    = 2'b10;
      ej.ejectReady = 1'b1;
      set_ports(4'b1111, HDR_MATCH);
      for (int c = 0; c < 2; c++) begin
         step(1);
         chk("rst_grant", 32'(ej.grant), 32'd0);
         chk("rst_busy", 32'(ej.busy), 32'd0);
         chk("rst_ejectValid", 32'(ej.ejectValid), 32'd0);
         chk("rst_acks", 32'(acks), 32'd0);
      end
      rst = 1'b0;
      set_ports(4'b0000, HDR_MATCH);
      #1;
      chk("post_rst_grant", 32'(ej.grant), 32'd0);
      chk("post_rst_busy", 32'(ej.busy), 32'd0);
      chk("post_rst_ejectValid", 32'(ej.ejectValid), 32'd0);
      chk("post_rst_acks", 32'(acks), 32'd0);

      // Single match on port3, then port4 beats port1
      set_ports(4'b0100, HDR_MATCH);
      push(3, 4);
      step(1);
      chk("single_grant", 32'(ej.grant), 32'h4);
      chk("single_sel", 32'(ej.ejectSel), 32'd2);
      step(4);
      chk("single_release_grant", 32'(ej.grant), 32'd0);
      chk("single_release_busy", 32'(ej.busy), 32'd0);
      set_ports(4'b1001, HDR_MATCH);
      push(4, 4);
      step(1);
      chk("p4_over_p1_grant", 32'(ej.grant), 32'h8);
      chk("p4_over_p1_sel", 32'(ej.ejectSel), 32'd3);
      step(4);
      set_ports(4'b0000, HDR_MATCH);
      chk("p4_release_grant", 32'(ej.grant), 32'd0);

      // Header mismatch held 20 cycles
      set_ports(4'b0001, 8'b10101001);
      for (int c = 0; c < 20; c++) begin
         step(1);
         chk("mismatch_grant", 32'(ej.grant), 32'd0);
      end
      set_ports(4'b0000, HDR_MATCH);
      step(1);

      // Round-robin with all ports requesting
      set_ports(4'b1111, HDR_MATCH);
      foreach (order[k]) push(order[k], 4);
      foreach (order[k]) begin
         step(1);
         chk("rr_grant", 32'(ej.grant), 32'(4'b0001 << (order[k] - 1)));
         chk("rr_sel", 32'(ej.ejectSel), 32'(order[k] - 1));
         step(4);
         chk("rr_idle_grant", 32'(ej.grant), 32'd0);
         chk("rr_idle_busy", 32'(ej.busy), 32'd0);
      end
      set_ports(4'b0000, HDR_MATCH);

      // Backpressure and owner stall on port2
      set_ports(4'b0010, HDR_MATCH);
      push(2, 4);
      step(1);
      chk("bp_grant", 32'(ej.grant), 32'h2);
      for (int i = 0; i < 9; i++) begin
         ej.valid2     = vt[i][0];
         ej.ejectReady = rt[i][0];
         #1;
         chk("bp_ejectValid", 32'(ej.ejectValid), 32'(vt[i]));
         chk("bp_ack", 32'(acks), (vt[i] == 1 && rt[i] == 1) ? 32'h2 : 32'h0);
         chk("bp_busy", 32'(ej.busy), 32'd1);
         @(posedge clk);
         #1;
      end
      chk("bp_release_busy", 32'(ej.busy), 32'd0);
      chk("bp_release_grant", 32'(ej.grant), 32'd0);
      set_ports(4'b0000, HDR_MATCH);
      ej.ejectReady = 1'b1;

      // Reset in the middle of a port3 packet
      set_ports(4'b0100, HDR_MATCH);
      push(3, 2);
      step(1);
      chk("mid_rst_grant_before", 32'(ej.grant), 32'h4);
      step(2);
      rst = 1'b1;
      #1;
      chk("mid_rst_ack", 32'(acks), 32'd0);
      chk("mid_rst_ejectValid", 32'(ej.ejectValid), 32'd0);
      step(1);
      chk("mid_rst_grant_after", 32'(ej.grant), 32'd0);
      chk("mid_rst_busy_after", 32'(ej.busy), 32'd0);
      rst = 1'b0;
      set_ports(4'b1111, HDR_MATCH);
      push(1, 4);
      step(1);
      chk("after_rst_grant", 32'(ej.grant), 32'h1);
      step(4);
      set_ports(4'b0000, HDR_MATCH);
      chk("after_rst_release", 32'(ej.grant), 32'd0);

      step(3);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
